data_mem_responder: RTL

Word-organised data memory that acts as the responding end of the CPU load/store port. It accepts one request per cycle on a valid/ready request channel, performs the access on a synchronous single-port RAM, and returns an in-order response for every request (read data or write acknowledge) on a valid/ready response channel with back-pressure. It sits between the core's memory stage and the data RAM, replacing direct array access.

---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Word-organised data memory acting as the responding end of the
//            CPU load/store port. One request per cycle is accepted on a
//            valid/ready channel, the access is done on a synchronous
//            single-port RAM, and an in-order response (load data or store
//            acknowledge) is returned on a valid/ready channel.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/req_ready - request handshake
//            req_we/req_addr     - store flag, byte address
//            req_wdata/req_wstrb - store data, byte-lane enables
//            rsp_valid/rsp_ready - response handshake
//            rsp_rdata/rsp_err   - load data (0 for stores/faults), fault flag
//            rsp_we              - store flag of the request being answered
// Config   : DMEM_WSTRB_EN - when defined, req_wstrb selects written bytes;
//            otherwise every good store writes the full word.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int WORDS     = 512,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_we
);

  localparam int AW = $clog2(WORDS);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam logic [OW-1:0] c_DEPTH    = OW'(RSP_DEPTH);
  localparam logic [PW-1:0] c_LAST_PTR = PW'(RSP_DEPTH - 1);

  // Storage
  logic [31:0] mem_q [WORDS];
  logic [31:0] fifo_rdata_q [RSP_DEPTH];
  logic        fifo_err_q   [RSP_DEPTH];
  logic        fifo_we_q    [RSP_DEPTH];

  // Control state
  logic [OW-1:0] occ_q, occ_d;
  logic [OW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  // RAM output stage (one entry, always drains into the FIFO next edge)
  logic        s1_valid_q;
  logic        s1_we_q;
  logic        s1_err_q;
  logic [31:0] s1_rdata_q;

  logic          accept;
  logic          pop;
  logic          push;
  logic          req_err;
  logic          good_wr;
  logic          good_rd;
  logic [AW-1:0] widx;

  // occ counts the RAM stage plus FIFO entries, so a full count guarantees
  // the FIFO always has room for whatever the RAM stage pushes.
  assign req_ready = (occ_q < c_DEPTH) && !reset;
  assign accept    = req_valid && req_ready;
  assign push      = s1_valid_q;
  assign pop       = rsp_valid && rsp_ready;

  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign widx    = req_addr[AW+1:2];
  assign good_wr = accept && req_we && !req_err;
  assign good_rd = accept && !req_we && !req_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Memory array: not reset; accept already excludes the reset cycle.
  always_ff @(posedge clk) begin
    if (good_wr) begin
`ifdef DMEM_WSTRB_EN
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) begin
          mem_q[widx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
`else
      mem_q[widx] <= req_wdata;
`endif
    end
  end

`ifndef DMEM_WSTRB_EN
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
`endif

  // RAM read stage payload
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_we_q    <= req_we;
      s1_err_q   <= req_err;
      s1_rdata_q <= good_rd ? mem_q[widx] : 32'h0;
    end
  end

  // FIFO payload
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata_q[wptr_q] <= s1_rdata_q;
      fifo_err_q[wptr_q]   <= s1_err_q;
      fifo_we_q[wptr_q]    <= s1_we_q;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    fcnt_d = fcnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + OW'(1);
      2'b01:   fcnt_d = fcnt_q - OW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      fcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      fcnt_q     <= fcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      s1_valid_q <= accept;
    end
  end

  // Outputs come straight from the FIFO head, so they hold while stalled;
  // they are forced to zero whenever no response is present.
  assign rsp_valid = (fcnt_q != '0);
  assign rsp_rdata = rsp_valid ? fifo_rdata_q[rptr_q] : 32'h0;
  assign rsp_err   = rsp_valid && fifo_err_q[rptr_q];
  assign rsp_we    = rsp_valid && fifo_we_q[rptr_q];

endmodule
`default_nettype wire
